// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle shifter.
// Each request is preprocessed for 32/64-bit operation, issued once, and answered with a one-cycle response pulse.
module shift_arbiter #(
  parameter int data_width = 64  // only 64 is supported
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_op,
  input  logic                  req0_alu32,
  input  logic [data_width-1:0] req0_value,
  input  logic [data_width-1:0] req0_shift,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_op,
  input  logic                  req1_alu32,
  input  logic [data_width-1:0] req1_value,
  input  logic [data_width-1:0] req1_shift,

  output logic                  rsp0_valid,
  output logic [data_width-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [data_width-1:0] rsp1_data,

  output logic                  sh_stb,
  output logic                  sh_arith,
  output logic                  sh_left,
  output logic [data_width-1:0] sh_value,
  output logic [data_width-1:0] sh_shift,
  input  logic [data_width-1:0] sh_out,
  input  logic                  sh_ack
);

  localparam logic [2:0] FLUSH = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [1:0] OP_RSH  = 2'b01;
  localparam logic [1:0] OP_ARSH = 2'b10;

  localparam logic [1:0] FLUSH_LAST = 2'd2;

  logic [2:0]            state_q,     state_d;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic                  last_q,      last_d;
  logic                  grant_q,     grant_d;
  logic                  alu32_q,     alu32_d;
  logic                  sh_left_q,   sh_left_d;
  logic                  sh_arith_q,  sh_arith_d;
  logic [data_width-1:0] sh_value_q,  sh_value_d;
  logic [data_width-1:0] sh_shift_q,  sh_shift_d;
  logic [data_width-1:0] rsp0_data_q, rsp0_data_d;
  logic [data_width-1:0] rsp1_data_q, rsp1_data_d;

  // Round-robin: on a tie the requester not served last wins.
  logic grant_sel;
  logic accept;
  assign grant_sel  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign accept     = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_sel;
  assign req1_ready = accept &&  grant_sel;

  logic [1:0]            sel_op;
  logic                  sel_alu32;
  logic [data_width-1:0] sel_value;
  logic [data_width-1:0] sel_shift;
  assign sel_op    = grant_sel ? req1_op    : req0_op;
  assign sel_alu32 = grant_sel ? req1_alu32 : req0_alu32;
  assign sel_value = grant_sel ? req1_value : req0_value;
  assign sel_shift = grant_sel ? req1_shift : req0_shift;

  // Shift amounts are masked to the operation width; upper bits are don't-care.
  logic unused_shift_hi;
  assign unused_shift_hi = ^sel_shift[data_width-1:6];

  logic                  pre_left;
  logic                  pre_arith;
  logic [data_width-1:0] pre_value;
  logic [data_width-1:0] pre_shift;

  always_comb begin
    pre_arith = (sel_op == OP_ARSH);
    pre_left  = (sel_op != OP_RSH) && (sel_op != OP_ARSH);
    if (sel_alu32) begin
      pre_shift = {{(data_width-5){1'b0}}, sel_shift[4:0]};
      if (pre_arith) pre_value = {{(data_width-32){sel_value[31]}}, sel_value[31:0]};
      else           pre_value = {{(data_width-32){1'b0}}, sel_value[31:0]};
    end else begin
      pre_shift = {{(data_width-6){1'b0}}, sel_shift[5:0]};
      pre_value = sel_value;
    end
  end

  logic [data_width-1:0] result;
  assign result = alu32_q ? {{(data_width-32){1'b0}}, sh_out[31:0]} : sh_out;

  always_comb begin
    // NOTE: every next-state signal starts at its held value so no path leaves one unassigned (no latches).
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    alu32_d     = alu32_q;
    sh_left_d   = sh_left_q;
    sh_arith_d  = sh_arith_q;
    sh_value_d  = sh_value_q;
    sh_shift_d  = sh_shift_q;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;

    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = 2'd0;
          state_d     = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      IDLE: begin
        if (accept) begin
          grant_d    = grant_sel;
          alu32_d    = sel_alu32;
          sh_left_d  = pre_left;
          sh_arith_d = pre_arith;
          sh_value_d = pre_value;
          sh_shift_d = pre_shift;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // The acknowledge is only meaningful here; stale ones elsewhere fall through.
        if (sh_ack) begin
          if (grant_q) rsp1_data_d = result;
          else         rsp0_data_d = result;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        flush_cnt_d = 2'd0;
        state_d     = FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      // NOTE: datapath registers are reset too, because their reset value is observable on the ports.
      state_q     <= FLUSH;
      flush_cnt_q <= 2'd0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      alu32_q     <= 1'b0;
      sh_left_q   <= 1'b0;
      sh_arith_q  <= 1'b0;
      sh_value_q  <= '0;
      sh_shift_q  <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      alu32_q     <= alu32_d;
      sh_left_q   <= sh_left_d;
      sh_arith_q  <= sh_arith_d;
      sh_value_q  <= sh_value_d;
      sh_shift_q  <= sh_shift_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

  assign sh_stb     = (state_q == ISSUE) && !rst;
  assign rsp0_valid = (state_q == RESP) && !grant_q && !rst;
  assign rsp1_valid = (state_q == RESP) &&  grant_q && !rst;
  assign sh_left    = sh_left_q;
  assign sh_arith   = sh_arith_q;
  assign sh_value   = sh_value_q;
  assign sh_shift   = sh_shift_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: randomized requesters, a two-cycle shifter model,
// and a transaction-level reference model that predicts grants, timing and results.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_op    = '0;
  logic [1:0]       req_alu32 = '0;
  logic [1:0][63:0] req_value = '0;
  logic [1:0][63:0] req_shift = '0;
  logic [1:0]       rsp_valid;
  logic [1:0][63:0] rsp_data;

  logic        sh_stb, sh_arith, sh_left, sh_ack;
  logic [63:0] sh_value, sh_shift, sh_out;

  shift_arbiter #(.data_width(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_op    (req_op[0]),
    .req0_alu32 (req_alu32[0]),
    .req0_value (req_value[0]),
    .req0_shift (req_shift[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_op    (req_op[1]),
    .req1_alu32 (req_alu32[1]),
    .req1_value (req_value[1]),
    .req1_shift (req_shift[1]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_data  (rsp_data[0]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_data  (rsp_data[1]),
    .sh_stb     (sh_stb),
    .sh_arith   (sh_arith),
    .sh_left    (sh_left),
    .sh_value   (sh_value),
    .sh_shift   (sh_shift),
    .sh_out     (sh_out),
    .sh_ack     (sh_ack)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected shifter operands and final result for one request, from the operation rules.
  typedef struct {
    logic [63:0] val;
    logic [63:0] sh;
    logic [63:0] res;
    bit          left;
    bit          arith;
  } exp_t;

  function automatic exp_t model(input logic [1:0] op, input bit alu32,
                                 input logic [63:0] value, input logic [63:0] shift);
    exp_t        e;
    int          amt;
    logic [63:0] full;
    amt     = alu32 ? int'(shift % 64'd32) : int'(shift % 64'd64);
    e.left  = (op == 2'b00) || (op == 2'b11);
    e.arith = (op == 2'b10);
    if (!alu32)       e.val = value;
    else if (e.arith) e.val = 64'(longint'(int'(value[31:0])));
    else              e.val = 64'(value[31:0]);
    e.sh = 64'(amt);
    if (e.left)       full = e.val << amt;
    else if (e.arith) full = $signed(e.val) >>> amt;
    else              full = e.val >> amt;
    e.res = alu32 ? (full & 64'h0000_0000_FFFF_FFFF) : full;
    return e;
  endfunction

  // Shifter model: acknowledges two cycles after the strobe; drives junk otherwise.
  initial begin
    int          dly;
    logic [63:0] pend;
    dly    = 0;
    pend   = '0;
    sh_ack = 1'b0;
    sh_out = '0;
    forever begin
      @(negedge clk);
      sh_ack = 1'b0;
      sh_out = {$urandom, $urandom};
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          sh_ack = 1'b1;
          sh_out = pend;
        end
      end
      if (sh_stb) begin
        dly = 2;
        if (sh_left)       pend = sh_value << sh_shift;
        else if (sh_arith) pend = $signed(sh_value) >>> sh_shift;
        else               pend = sh_value >> sh_shift;
      end
    end
  end

  // Reference model and monitor, evaluated mid-cycle.
  int               flush_left = 0;
  bit               inflight   = 0;
  int               age        = 0;
  bit               g_q        = 0;
  exp_t             e_cur;
  bit               last_srv   = 1;
  logic [1:0][63:0] last_data  = '0;
  bit               rst_prev   = 0;
  int               grant_log[$];
  int               rsp_cnt[2] = '{0, 0};
  logic [63:0]      cap_sh_value, cap_sh_shift;
  logic [1:0][63:0] cap_rsp;

  always @(negedge clk) begin : monitor
    bit       idle, g;
    logic [1:0] exp_rdy, exp_rsp;
    bit       exp_stb;
    if (rst) begin
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_stb", 64'(sh_stb), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      if (rst_prev) begin
        check("rst_sh_value", sh_value, 64'd0);
        check("rst_sh_shift", sh_shift, 64'd0);
        check("rst_sh_mode", 64'({sh_left, sh_arith}), 64'd0);
        check("rst_rsp0_data", rsp_data[0], 64'd0);
        check("rst_rsp1_data", rsp_data[1], 64'd0);
      end
      inflight   = 0;
      flush_left = 3;
      last_srv   = 1;
      last_data  = '0;
    end else begin
      if (rst_prev) begin
        check("post_rst_sh_value", sh_value, 64'd0);
        check("post_rst_sh_shift", sh_shift, 64'd0);
      end
      idle    = !inflight && (flush_left == 0);
      g       = (req_valid[0] && req_valid[1]) ? !last_srv : req_valid[1];
      exp_rdy = 2'b00;
      if (idle && (req_valid != 2'b00)) exp_rdy[g] = 1'b1;
      check("ready", 64'(req_ready), 64'(exp_rdy));
      if (flush_left > 0) flush_left--;
      exp_stb = 0;
      exp_rsp = 2'b00;
      if (inflight) begin
        age++;
        exp_stb = (age == 1);
        check("sh_value", sh_value, e_cur.val);
        check("sh_shift", sh_shift, e_cur.sh);
        check("sh_left", 64'(sh_left), 64'(e_cur.left));
        check("sh_arith", 64'(sh_arith), 64'(e_cur.arith));
        if (age == 4) begin
          exp_rsp[g_q]   = 1'b1;
          last_data[g_q] = e_cur.res;
          last_srv       = g_q;
          inflight       = 0;
        end
      end
      check("sh_stb", 64'(sh_stb), 64'(exp_stb));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      check("rsp0_data", rsp_data[0], last_data[0]);
      check("rsp1_data", rsp_data[1], last_data[1]);
      if (sh_stb) begin
        cap_sh_value = sh_value;
        cap_sh_shift = sh_shift;
      end
      for (int n = 0; n < 2; n++) begin
        if (rsp_valid[n]) begin
          cap_rsp[n] = rsp_data[n];
          rsp_cnt[n]++;
        end
      end
      if (exp_rdy != 2'b00) begin
        inflight = 1;
        age      = 0;
        g_q      = g;
        e_cur    = model(req_op[g], req_alu32[g], req_value[g], req_shift[g]);
        grant_log.push_back(int'(g));
      end
    end
    rst_prev = rst;
  end

  // Stimulus is changed 1 time unit after a rising edge; ready is sampled mid-cycle.
  task automatic settle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_one(input int n, input logic [1:0] op, input logic alu32,
                           input logic [63:0] value, input logic [63:0] shift,
                           output int waited);
    req_op[n]    = op;
    req_alu32[n] = alu32;
    req_value[n] = value;
    req_shift[n] = shift;
    req_valid[n] = 1'b1;
    waited       = 0;
    forever begin
      @(negedge clk);
      if (req_ready[n] || waited >= 200) break;
      waited++;
    end
    check($sformatf("accept_r%0d", n), 64'(req_ready[n]), 64'd1);
    if (req_ready[n]) begin
      @(posedge clk);
      #1;
    end
    req_valid[n] = 1'b0;
  endtask

  function automatic logic [63:0] rand_shift();
    if ($urandom_range(0, 1) == 0) return {$urandom, $urandom};
    return 64'($urandom_range(0, 70));
  endfunction

  task automatic drive(input int n, input int cnt, input bit gaps);
    int w;
    for (int k = 0; k < cnt; k++) begin
      if (gaps) settle($urandom_range(0, 3));
      drive_one(n, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, rand_shift(), w);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    int w;
    int c0, c1;
    int exp_order[4] = '{0, 1, 0, 1};

    settle(3);
    rst = 1'b0;

    // Both requesters saturated right after reset: strict alternation starting at 0.
    grant_log.delete();
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    fork
      drive(0, 2, 1'b0);
      drive(1, 2, 1'b0);
    join
    settle(6);
    check("order_len", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("order_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    check("order_rsp0_cnt", 64'(rsp_cnt[0] - c0), 64'd2);
    check("order_rsp1_cnt", 64'(rsp_cnt[1] - c1), 64'd2);

    // Directed operand and result cases.
    drive_one(0, 2'b00, 1'b0, 64'h1, 64'h44, w);
    settle(6);
    check("lsh64_data", cap_rsp[0], 64'h10);
    drive_one(1, 2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'd4, w);
    settle(6);
    check("arsh32_sh_value", cap_sh_value, 64'hFFFF_FFFF_8000_0000);
    check("arsh32_data", cap_rsp[1], 64'h0000_0000_F800_0000);
    drive_one(0, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h21, w);
    settle(6);
    check("rsh32_sh_shift", cap_sh_shift, 64'd1);
    check("rsh32_data", cap_rsp[0], 64'h0000_0000_7FFF_FFFF);
    drive_one(1, 2'b11, 1'b0, 64'h3, 64'd1, w);
    settle(6);
    check("reserved_lsh_data", cap_rsp[1], 64'h6);
    drive_one(0, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd63, w);
    settle(6);
    check("arsh64_max_data", cap_rsp[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized contention with idle gaps.
    fork
      drive(0, 40, 1'b1);
      drive(1, 40, 1'b1);
    join
    settle(6);

    // Reset while waiting on the shifter; its late acknowledge must be ignored.
    drive_one(0, 2'b00, 1'b0, 64'h5, 64'd1, w);
    settle(1);
    c0  = rsp_cnt[0];
    rst = 1'b1;
    settle(1);
    rst = 1'b0;
    drive_one(1, 2'b01, 1'b0, 64'hF0, 64'd4, w);
    check("flush_wait_cycles", 64'(w), 64'd3);
    settle(6);
    check("abort_no_rsp0", 64'(rsp_cnt[0] - c0), 64'd0);
    check("after_abort_data", cap_rsp[1], 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter data_width, default 64: operand and result width; only 64 is supported.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N = 0, 1) has a shift request; held high until accepted.
REQ-005 reqN_ready  output  1  request N accepted in this cycle when reqN_valid is also high.
REQ-006 reqN_op  input  2  operation: 00 = lsh, 01 = rsh, 10 = arsh, 11 = reserved (executed as lsh).
REQ-007 reqN_alu32  input  1  1 = 32-bit ALU op, 0 = 64-bit op.
REQ-008 reqN_value  input  data_width  operand to shift.
REQ-009 reqN_shift  input  data_width  shift amount, unmasked.
REQ-010 rspN_valid  output  1  one-cycle pulse: rspN_data is valid for requester N.
REQ-011 rspN_data  output  data_width  shift result for requester N.
REQ-012 sh_stb, sh_arith, sh_left  output  1 each  shifter strobe and mode controls.
REQ-013 sh_value, sh_shift  output  data_width  shifter operands.
REQ-014 sh_out  input  data_width; sh_ack  input  1  shifter result and completion pulse.

Function
REQ-015 The FSM SHALL have states FLUSH, IDLE, ISSUE, WAIT and RESP.
REQ-016 FLUSH SHALL last exactly 3 cycles, counted by a 2-bit counter, then go to IDLE; no request is accepted in FLUSH.
REQ-017 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester, and only when that requester's valid is high.
REQ-018 Arbitration SHALL be round-robin: when both valids are high, grant the requester not served last; with one valid, grant it.
REQ-019 Acceptance SHALL latch op, alu32, value, shift and the grant index, then go to ISSUE.
REQ-020 Operand preprocessing SHALL be as follows:
- 64-bit: sh_value = value; sh_shift = {58'b0, shift[5:0]}.
- 32-bit: sh_shift = {59'b0, shift[4:0]}.
- 32-bit arsh: sh_value = sign-extension of value[31:0].
- 32-bit lsh/rsh: sh_value = zero-extension of value[31:0].
REQ-021 Mode SHALL be: sh_left = 1 for lsh or reserved, 0 otherwise; sh_arith = 1 only for arsh.
REQ-022 In ISSUE, sh_stb SHALL be high for exactly one cycle, then the FSM goes to WAIT; sh_stb SHALL be low in every other state.
REQ-023 sh_value, sh_shift, sh_left and sh_arith SHALL hold stable from ISSUE until the response is produced.
REQ-024 In WAIT, a cycle with sh_ack = 1 SHALL capture the result and move to RESP:
- 64-bit: result = sh_out.
- 32-bit: result = {32'b0, sh_out[31:0]}.
REQ-025 In RESP, rspN_valid SHALL be high for the granted N for exactly one cycle with rspN_data = result; the FSM then goes to IDLE and records N as last served.
REQ-026 sh_ack SHALL be ignored in every state except WAIT.
REQ-027 rspN_data SHALL hold its last value until the next response to requester N.
REQ-028 Requests arriving outside IDLE SHALL wait with reqN_ready low; no request is lost or duplicated.
REQ-029 Throughput SHALL be at most one request in flight; the next acceptance occurs no earlier than the cycle after RESP.

Reset
REQ-030 rst = 1 at a clock edge SHALL force state FLUSH with the counter cleared and last-served = 1, so req0 wins the first tie.
REQ-031 While reset is applied and after it, sh_stb, reqN_ready, rspN_valid, sh_left and sh_arith SHALL be 0, and sh_value, sh_shift and rspN_data SHALL be 0.
REQ-032 Reset during ISSUE, WAIT or RESP SHALL abort the operation with no response pulse; a later stale sh_ack SHALL be discarded by REQ-026 and REQ-016.

Verification
REQ-033 Bench shifter model: ack two cycles after stb. Scenario: req0 accepted in cycle T with 64-bit lsh, value = 0x1, shift = 0x44 -> sh_stb high at T+1, rsp0_valid at T+4, rsp0_data = 0x10.
REQ-034 Scenario: req1 32-bit arsh, value = 0x00000000_80000000, shift = 4 -> sh_value = 0xFFFFFFFF_80000000, rsp1_data = 0x00000000_F8000000.
REQ-035 Scenario: both valids held high for 4 consecutive requests after reset -> grant order is 0, 1, 0, 1, with each rspN_valid pulsing exactly once per request.
REQ-036 Scenario: 32-bit rsh, value = 0xFFFFFFFF_FFFFFFFF, shift = 0x21 -> sh_shift = 1, rsp_data = 0x00000000_7FFFFFFF.
REQ-037 Scenario: rst asserted in WAIT, model acks one cycle later -> no rspN_valid; reqN_ready stays low for 3 cycles after reset deassertion; the next request completes correctly.
